// File: rtl/ras_ckpt_if.sv
// Fetch-side bundle for the return-address stack:
// request, recovery and prediction/checkpoint signals.
interface ras_ckpt_if #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32,
  parameter int PTR_W = $clog2(DEPTH)
) ();
  logic             req_valid;
  logic [6:0]       opcode;
  logic [4:0]       rd_addr;
  logic [4:0]       rs1_addr;
  logic [WIDTH-1:0] pc;
  logic             recover;
  logic [PTR_W-1:0] rec_ptr;
  logic [PTR_W:0]   rec_cnt;
  logic [WIDTH-1:0] rec_top;
  logic             pred_valid;
  logic [WIDTH-1:0] pred_addr;
  logic [PTR_W-1:0] ckpt_ptr;
  logic [PTR_W:0]   ckpt_cnt;
  logic [WIDTH-1:0] ckpt_top;
  logic [PTR_W:0]   count;

  modport master (
    output req_valid, opcode, rd_addr,
    output rs1_addr, pc, recover,
    output rec_ptr, rec_cnt, rec_top,
    input  pred_valid, pred_addr,
    input  ckpt_ptr, ckpt_cnt, ckpt_top,
    input  count
  );

  modport slave (
    input  req_valid, opcode, rd_addr,
    input  rs1_addr, pc, recover,
    input  rec_ptr, rec_cnt, rec_top,
    output pred_valid, pred_addr,
    output ckpt_ptr, ckpt_cnt, ckpt_top,
    output count
  );
endinterface

// File: rtl/ras_ckpt.sv
// Checkpointed return-address stack for fetch:
// link-register classification, prediction, recovery.
module ras_ckpt #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input logic     clk,
  input logic     rst,
  ras_ckpt_if.slave bus
);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_PUSH,
    OP_POP,
    OP_POPPUSH
  } ras_op_e;

  logic [WIDTH-1:0] stack [DEPTH];
  logic [PTR_W-1:0] ptr;
  logic [CNT_W-1:0] cnt;

  ras_op_e          op;
  logic             rd_link;
  logic             rs_link;
  logic             is_jal;
  logic             is_jalr;
  logic             empty;
  logic             full;
  logic [PTR_W-1:0] top_idx;
  logic [PTR_W-1:0] rec_idx;
  logic [WIDTH-1:0] top;
  logic [WIDTH-1:0] ret_addr;

  assign top_idx  = ptr - PTR_W'(1);
  assign rec_idx  = bus.rec_ptr - PTR_W'(1);
  assign top      = stack[top_idx];
  assign ret_addr = bus.pc + WIDTH'(4);
  assign empty    = (cnt == '0);
  assign full     = (cnt == CNT_W'(DEPTH));
  assign is_jal   = (bus.opcode == OPC_JAL);
  assign is_jalr  = (bus.opcode == OPC_JALR);

  // Classify the request by its link registers; recovery masks it.
  always_comb begin
    op      = OP_NONE;
    rd_link = (bus.rd_addr == 5'd1)
           || (bus.rd_addr == 5'd5);
    rs_link = (bus.rs1_addr == 5'd1)
           || (bus.rs1_addr == 5'd5);
    if (bus.req_valid && !bus.recover) begin
      unique case (1'b1)
        is_jal: begin
          if (rd_link) op = OP_PUSH;
        end
        is_jalr: begin
          unique case ({rd_link, rs_link})
            2'b01: op = OP_POP;
            2'b10: op = OP_PUSH;
            2'b11: begin
              if (bus.rd_addr != bus.rs1_addr)
                op = OP_POPPUSH;
              else
                op = OP_PUSH;
            end
            default: op = OP_NONE;
          endcase
        end
        default: op = OP_NONE;
      endcase
    end
  end

  // Zero-latency prediction and checkpoint of pre-request state.
  always_comb begin
    bus.pred_valid = 1'b0;
    bus.pred_addr  = '0;
    bus.ckpt_ptr   = '0;
    bus.ckpt_cnt   = '0;
    bus.ckpt_top   = '0;
    bus.count      = cnt;
    if ((op == OP_POP || op == OP_POPPUSH)
        && !empty) begin
      bus.pred_valid = 1'b1;
      bus.pred_addr  = top;
    end
    if (bus.req_valid) begin
      bus.ckpt_ptr = ptr;
      bus.ckpt_cnt = cnt;
      bus.ckpt_top = top;
    end
  end

  // Stack state: recovery first, then push/pop updates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++)
        stack[i] <= '0;
    end else if (bus.recover) begin
      ptr            <= bus.rec_ptr;
      cnt            <= bus.rec_cnt;
      stack[rec_idx] <= bus.rec_top;
    end else begin
      unique case (op)
        OP_PUSH: begin
          stack[ptr] <= ret_addr;
          ptr        <= ptr + PTR_W'(1);
          if (!full) cnt <= cnt + CNT_W'(1);
        end
        OP_POP: begin
          if (!empty) begin
            ptr <= top_idx;
            cnt <= cnt - CNT_W'(1);
          end
        end
        OP_POPPUSH: begin
          if (!empty) begin
            stack[top_idx] <= ret_addr;
          end else begin
            stack[ptr] <= ret_addr;
            ptr        <= ptr + PTR_W'(1);
            cnt        <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ras_ckpt.sv
// Directed bench for ras_ckpt: push/pop, overflow,
// pop-push, checkpoint recovery and async reset.
module tb_ras_ckpt;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;

  logic clk;
  logic rst;
  int   vecs;
  int   errs;

  logic [3:0]  cp_ptr;
  logic [4:0]  cp_cnt;
  logic [31:0] cp_top;

  ras_ckpt_if #(.DEPTH(16), .WIDTH(32)) bus ();

  ras_ckpt #(.DEPTH(16), .WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [6:0] op,
                     input logic [4:0] rd,
                     input logic [4:0] rs,
                     input logic [31:0] p);
    bus.req_valid = 1'b1;
    bus.opcode    = op;
    bus.rd_addr   = rd;
    bus.rs1_addr  = rs;
    bus.pc        = p;
  endtask

  task automatic idle();
    bus.req_valid = 1'b0;
    bus.opcode    = 7'd0;
    bus.rd_addr   = 5'd0;
    bus.rs1_addr  = 5'd0;
    bus.pc        = 32'd0;
    bus.recover   = 1'b0;
    bus.rec_ptr   = 4'd0;
    bus.rec_cnt   = 5'd0;
    bus.rec_top   = 32'd0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic push(input logic [31:0] p);
    req(JAL, 5'd1, 5'd0, p);
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b0;
    #2;
    req(JALR, 5'd0, 5'd1, 32'h40);
    #1;
    vecs++;
    if (bus.count !== 5'd0) begin
      errs++;
      $display("FAIL rst_count got %0d exp 0", bus.count);
    end
    vecs++;
    if (bus.pred_valid !== 1'b0 || bus.pred_addr !== 32'd0) begin
      errs++;
      $display("FAIL rst_pred got %b/%h exp 0/0",
               bus.pred_valid, bus.pred_addr);
    end
    tick();
    rst = 1'b1;
    tick();
    #1;
    vecs++;
    if (bus.pred_valid !== 1'b0 || bus.ckpt_ptr !== 4'd0
        || bus.ckpt_cnt !== 5'd0) begin
      errs++;
      $display("FAIL empty_pop got v%b p%0d c%0d exp v0 p0 c0",
               bus.pred_valid, bus.ckpt_ptr, bus.ckpt_cnt);
    end
    tick();
    idle();
    vecs++;
    if (bus.count !== 5'd0) begin
      errs++;
      $display("FAIL empty_pop_count got %0d exp 0", bus.count);
    end
  endtask

  task automatic test_push_pop();
    do_reset();
    push(32'h100);
    vecs++;
    if (bus.count !== 5'd1) begin
      errs++;
      $display("FAIL push_count got %0d exp 1", bus.count);
    end
    req(JALR, 5'd0, 5'd1, 32'h180);
    #1;
    vecs++;
    if (bus.pred_valid !== 1'b1 || bus.pred_addr !== 32'h104) begin
      errs++;
      $display("FAIL pop_pred got %b/%h exp 1/104",
               bus.pred_valid, bus.pred_addr);
    end
    vecs++;
    if (bus.ckpt_ptr !== 4'd1 || bus.ckpt_cnt !== 5'd1
        || bus.ckpt_top !== 32'h104) begin
      errs++;
      $display("FAIL pop_ckpt got %0d/%0d/%h exp 1/1/104",
               bus.ckpt_ptr, bus.ckpt_cnt, bus.ckpt_top);
    end
    tick();
    idle();
    vecs++;
    if (bus.count !== 5'd0) begin
      errs++;
      $display("FAIL pop_count got %0d exp 0", bus.count);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] exp;
    logic        ev;
    do_reset();
    for (int i = 0; i < 17; i++)
      push(32'h1000 + 32'(16 * i));
    vecs++;
    if (bus.count !== 5'd16) begin
      errs++;
      $display("FAIL ovf_count got %0d exp 16", bus.count);
    end
    for (int i = 0; i < 17; i++) begin
      ev  = (i < 16);
      exp = ev ? 32'h1104 - 32'(16 * i) : 32'd0;
      req(JALR, 5'd0, 5'd5, 32'h2000);
      #1;
      vecs++;
      if (bus.pred_valid !== ev || bus.pred_addr !== exp) begin
        errs++;
        $display("FAIL ovf_pop%0d got %b/%h exp %b/%h",
                 i, bus.pred_valid, bus.pred_addr, ev, exp);
      end
      tick();
    end
    idle();
    vecs++;
    if (bus.count !== 5'd0) begin
      errs++;
      $display("FAIL ovf_drain got %0d exp 0", bus.count);
    end
  endtask

  task automatic test_poppush();
    do_reset();
    push(32'h100);
    push(32'h204);
    req(JALR, 5'd5, 5'd1, 32'h300);
    #1;
    vecs++;
    if (bus.pred_valid !== 1'b1 || bus.pred_addr !== 32'h208) begin
      errs++;
      $display("FAIL pp_pred got %b/%h exp 1/208",
               bus.pred_valid, bus.pred_addr);
    end
    tick();
    idle();
    vecs++;
    if (bus.count !== 5'd2) begin
      errs++;
      $display("FAIL pp_count got %0d exp 2", bus.count);
    end
    req(JALR, 5'd0, 5'd1, 32'h0);
    #1;
    vecs++;
    if (bus.pred_valid !== 1'b1 || bus.pred_addr !== 32'h304) begin
      errs++;
      $display("FAIL pp_pop1 got %b/%h exp 1/304",
               bus.pred_valid, bus.pred_addr);
    end
    tick();
    #1;
    vecs++;
    if (bus.pred_valid !== 1'b1 || bus.pred_addr !== 32'h104) begin
      errs++;
      $display("FAIL pp_pop2 got %b/%h exp 1/104",
               bus.pred_valid, bus.pred_addr);
    end
    tick();
    idle();
    req(JALR, 5'd1, 5'd5, 32'h500);
    #1;
    vecs++;
    if (bus.pred_valid !== 1'b0) begin
      errs++;
      $display("FAIL pp_empty got %b exp 0", bus.pred_valid);
    end
    tick();
    idle();
    vecs++;
    if (bus.count !== 5'd1) begin
      errs++;
      $display("FAIL pp_empty_cnt got %0d exp 1", bus.count);
    end
  endtask

  task automatic recover_ckpt();
    bus.recover = 1'b1;
    bus.rec_ptr = cp_ptr;
    bus.rec_cnt = cp_cnt;
    bus.rec_top = cp_top;
    tick();
    idle();
  endtask

  task automatic test_recover();
    do_reset();
    push(32'h400);
    push(32'h404);
    push(32'h408);
    req(JAL, 5'd1, 5'd0, 32'h500);
    #1;
    cp_ptr = bus.ckpt_ptr;
    cp_cnt = bus.ckpt_cnt;
    cp_top = bus.ckpt_top;
    vecs++;
    if (cp_ptr !== 4'd3 || cp_cnt !== 5'd3 || cp_top !== 32'h40C) begin
      errs++;
      $display("FAIL ckpt_cap got %0d/%0d/%h exp 3/3/40c",
               cp_ptr, cp_cnt, cp_top);
    end
    tick();
    push(32'h510);
    req(JALR, 5'd1, 5'd5, 32'h600);
    #1;
    vecs++;
    if (bus.pred_valid !== 1'b1 || bus.pred_addr !== 32'h514) begin
      errs++;
      $display("FAIL wp_pp got %b/%h exp 1/514",
               bus.pred_valid, bus.pred_addr);
    end
    tick();
    idle();
    recover_ckpt();
    vecs++;
    if (bus.count !== 5'd3) begin
      errs++;
      $display("FAIL rec_count got %0d exp 3", bus.count);
    end
    req(JALR, 5'd1, 5'd5, 32'h700);
    tick();
    idle();
    recover_ckpt();
    req(JALR, 5'd0, 5'd1, 32'h0);
    #1;
    vecs++;
    if (bus.pred_valid !== 1'b1 || bus.pred_addr !== 32'h40C) begin
      errs++;
      $display("FAIL rec_pop1 got %b/%h exp 1/40c",
               bus.pred_valid, bus.pred_addr);
    end
    tick();
    #1;
    vecs++;
    if (bus.pred_valid !== 1'b1 || bus.pred_addr !== 32'h408) begin
      errs++;
      $display("FAIL rec_pop2 got %b/%h exp 1/408",
               bus.pred_valid, bus.pred_addr);
    end
    tick();
    idle();
  endtask

  task automatic test_recover_priority();
    req(JAL, 5'd1, 5'd0, 32'h900);
    bus.recover = 1'b1;
    bus.rec_ptr = 4'd5;
    bus.rec_cnt = 5'd5;
    bus.rec_top = 32'hABC;
    #1;
    vecs++;
    if (bus.pred_valid !== 1'b0) begin
      errs++;
      $display("FAIL pri_pred got %b exp 0", bus.pred_valid);
    end
    tick();
    idle();
    vecs++;
    if (bus.count !== 5'd5) begin
      errs++;
      $display("FAIL pri_count got %0d exp 5", bus.count);
    end
    req(JALR, 5'd0, 5'd1, 32'h0);
    #1;
    vecs++;
    if (bus.pred_valid !== 1'b1 || bus.pred_addr !== 32'hABC) begin
      errs++;
      $display("FAIL pri_pop got %b/%h exp 1/abc",
               bus.pred_valid, bus.pred_addr);
    end
    tick();
    req(JALR, 5'd5, 5'd1, 32'hA00);
    bus.recover = 1'b1;
    bus.rec_ptr = 4'd2;
    bus.rec_cnt = 5'd2;
    bus.rec_top = 32'h123;
    #1;
    vecs++;
    if (bus.pred_valid !== 1'b0 || bus.pred_addr !== 32'd0) begin
      errs++;
      $display("FAIL pri_pp got %b/%h exp 0/0",
               bus.pred_valid, bus.pred_addr);
    end
    tick();
    idle();
    req(JALR, 5'd0, 5'd1, 32'h0);
    #1;
    vecs++;
    if (bus.pred_valid !== 1'b1 || bus.pred_addr !== 32'h123
        || bus.ckpt_cnt !== 5'd2) begin
      errs++;
      $display("FAIL pri_pop2 got %b/%h/%0d exp 1/123/2",
               bus.pred_valid, bus.pred_addr, bus.ckpt_cnt);
    end
    tick();
    idle();
  endtask

  task automatic test_async_reset();
    do_reset();
    push(32'h800);
    push(32'h810);
    req(JALR, 5'd0, 5'd1, 32'h0);
    #1;
    vecs++;
    if (bus.pred_valid !== 1'b1 || bus.pred_addr !== 32'h814) begin
      errs++;
      $display("FAIL ar_pre got %b/%h exp 1/814",
               bus.pred_valid, bus.pred_addr);
    end
    rst = 1'b0;
    #1;
    vecs++;
    if (bus.count !== 5'd0 || bus.pred_valid !== 1'b0
        || bus.pred_addr !== 32'd0) begin
      errs++;
      $display("FAIL ar_out got c%0d %b/%h exp c0 0/0",
               bus.count, bus.pred_valid, bus.pred_addr);
    end
    vecs++;
    if (bus.ckpt_ptr !== 4'd0 || bus.ckpt_cnt !== 5'd0
        || bus.ckpt_top !== 32'd0) begin
      errs++;
      $display("FAIL ar_ckpt got %0d/%0d/%h exp 0/0/0",
               bus.ckpt_ptr, bus.ckpt_cnt, bus.ckpt_top);
    end
    tick();
    rst = 1'b1;
    tick();
    #1;
    vecs++;
    if (bus.pred_valid !== 1'b0) begin
      errs++;
      $display("FAIL ar_pop got %b exp 0", bus.pred_valid);
    end
    tick();
    idle();
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    rst  = 1'b0;
    idle();
    test_reset();
    test_push_pop();
    test_overflow();
    test_poppush();
    test_recover();
    test_recover_priority();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end
endmodule
